// File: rtl/fp_mac_acc.sv
// Fixed-point multiply-accumulate: signed integer activations times Q0.F weights, summed over
// a vector, then rounded half-up into an N-bit result. Define MAC_SAT_EN to saturate instead of wrap.
module fp_mac_acc #(
  parameter int N     = 8,
  parameter int F     = 7,
  parameter int ACC_W = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] in_a,
  input  logic signed [N-1:0] in_b,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out_result,
  output logic [7:0]          out_count
);

  // Width of the rounded value before it is reduced to N bits.
  localparam int RW = ACC_W + 1 - F;

  localparam logic signed [ACC_W:0]  ROUND_HALF = (ACC_W+1)'(1) << (F - 1);
  localparam logic signed [RW-1:0]   SAT_MAX    = RW'((2 ** (N - 1)) - 1);
  localparam logic signed [RW-1:0]   SAT_MIN    = RW'(-(2 ** (N - 1)));

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t                   r_state;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [N-1:0]      r_result;
  logic [7:0]               r_count;
  logic                     r_valid;

  logic signed [2*N-1:0]    w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [ACC_W:0]    w_round_sum;
  logic signed [RW-1:0]     w_rounded;
  logic signed [N-1:0]      w_result;

  assign w_prod     = in_a * in_b;
  assign w_prod_ext = ACC_W'(w_prod);

  // The first beat of a vector loads the accumulator rather than adding to it.
  assign w_acc_next = (r_state == IDLE) ? w_prod_ext : r_acc + w_prod_ext;

  // One extra bit keeps the rounding offset from overflowing a full-scale accumulator.
  assign w_round_sum = (ACC_W+1)'(w_acc_next) + ROUND_HALF;
  assign w_rounded   = RW'(w_round_sum >>> F);

  // NOTE: always_comb assigns its output on every path; a missing branch would infer a latch.
  always_comb begin
    w_result = w_rounded[N-1:0];
`ifdef MAC_SAT_EN
    if (w_rounded > SAT_MAX) begin
      w_result = SAT_MAX[N-1:0];
    end else if (w_rounded < SAT_MIN) begin
      w_result = SAT_MIN[N-1:0];
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_result <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc   <= w_acc_next;
            r_count <= 8'd1;
            if (in_last) begin
              r_result <= w_result;
              r_valid  <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_state  <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            r_acc <= w_acc_next;
            if (r_count != 8'hFF) begin
              r_count <= r_count + 8'd1;
            end
            if (in_last) begin
              r_result <= w_result;
              r_valid  <= 1'b1;
              r_state  <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_acc   <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = !rst && (r_state != DONE);
  assign out_valid  = r_valid;
  assign out_result = r_result;
  assign out_count  = r_count;

endmodule

// File: doc/fp_mac_acc.md
FP_MAC_ACC -- requirements
Module: fp_mac_acc

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter F, default 7, meaning fractional bits of weight operand b (Q0.F).
REQ-003 The block SHALL have parameter ACC_W, default 20, meaning accumulator width in bits.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  N  signed integer activation.
- in_b  in  N  signed Q0.F weight.
- in_last  in  1  final beat of current vector.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  N  signed rounded dot-product result.
- out_count  out  8  beats accepted in this vector, saturating at 255.

Function
REQ-005 The block SHALL implement states IDLE, ACCUM and DONE.
REQ-006 A beat SHALL be accepted on any rising edge where in_valid and in_ready are both 1; in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE.
REQ-007 On each accepted beat the block SHALL form the full 2N-bit signed product in_a*in_b, sign-extend it to ACC_W and add it to the accumulator, which wraps modulo 2^ACC_W.
REQ-008 The first beat accepted in IDLE SHALL load the accumulator with its product and move to ACCUM, or to DONE if in_last=1.
REQ-009 A beat accepted in ACCUM with in_last=1 SHALL move to DONE; with in_last=0 the block SHALL stay in ACCUM.
REQ-010 On entry to DONE, out_result SHALL be registered as (acc + 2^(F-1)) arithmetically shifted right by F, i.e. round-half-up, then reduced to N bits per REQ-017.
REQ-011 out_valid SHALL be 1 exactly while in DONE; out_result is visible one cycle after the last beat is accepted.
REQ-012 out_result and out_count SHALL hold stable while out_valid=1 and out_ready=0.
REQ-013 On out_valid and out_ready both 1, the block SHALL move to IDLE and clear the accumulator and out_count on the same edge.
REQ-014 Beats presented while in DONE SHALL be ignored; no back-to-back accept occurs on the handshake cycle.
REQ-015 In_valid deasserted in ACCUM SHALL leave the accumulator and state unchanged.

Reset
REQ-016 With rst=1 at a rising edge the block SHALL enter IDLE, clear the accumulator, and drive out_valid=0, out_result=0 and out_count=0, regardless of state; in_ready SHALL be 0 while rst=1.

Configuration
REQ-017 With macro MAC_SAT_EN defined, the rounded value SHALL saturate to [-2^(N-1), 2^(N-1)-1]; without it, the rounded value SHALL be truncated to its low N bits (two's-complement wrap).

Verification
REQ-018 Single beat: a=64, b=64, last=1 -> next cycle out_valid=1, out_result=32, out_count=1.
REQ-019 Three beats (10,127), (-20,64), (5,-128), the last with last=1 -> sum -650, out_result=-5, out_count=3.
REQ-020 Four beats a=127, b=127 -> sum 64516; out_result=127 with MAC_SAT_EN, -8 without.
REQ-021 Two beats a=-128, b=127 -> sum -32512; out_result=-128 with MAC_SAT_EN, 2 without.
REQ-022 Backpressure: hold out_ready=0 for 5 cycles after DONE while driving in_valid=1 -> out_result and out_valid stable, in_ready=0, no beats absorbed; out_ready=1 -> IDLE next cycle, following vector starts from a zero accumulator.
REQ-023 Reset mid-vector: rst=1 after 2 beats of a 4-beat vector -> next cycle out_valid=0 and out_count=0; a new single beat (64,64,last) yields 32.
